// File: rtl/cb_io_filter_pkg.sv
// Shared definitions for the multi-channel IO debounce filter: default
// geometry, the per-sample filter decision encoding and a clog2 helper.
package cb_io_filter_pkg;

  localparam int CH_NUM_DEF      = 8;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // What one synchronised sample does to a channel on the next edge.
  typedef enum logic [1:0] {
    FILT_DISABLED = 2'd0,  // channel gated off: counter cleared, level held
    FILT_HOLD     = 2'd1,  // sample agrees with the output: restart qualification
    FILT_COUNT    = 2'd2,  // sample disagrees, run not yet long enough
    FILT_UPDATE   = 2'd3   // sample disagrees and the run is long enough: switch
  } filt_action_e;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cb_io_filter_cell.sv
// One filter channel: synchroniser chain, consecutive-mismatch counter,
// filtered level and edge pulses, all registered on sys_clk.
module cb_io_filter_cell
  import cb_io_filter_pkg::*;
#(
  parameter int   CNT_W       = CNT_W_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic INIT_BIT    = 1'b0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             orign_opt_i,
  input  logic [CNT_W-1:0] filt_len_i,
  input  logic             ch_en_i,
  output logic             filter_opt_o,
  output logic             opt_rise_o,
  output logic             opt_fall_o,
  output logic             busy_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_bit;

  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   busy_q;
  logic                   busy_d;

  logic [CNT_W-1:0]       len_eff;
  logic [CNT_W:0]         cnt_inc;
  filt_action_e           action;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Shift the raw pin into the synchroniser; it runs regardless of enable.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], orign_opt_i};
  end

  // Classify the current synchronised sample against the filtered level.
  always_comb begin
    // A filter length of zero behaves exactly like one.
    len_eff = (filt_len_i == '0) ? CNT_W'(1) : filt_len_i;
    // One extra bit so a saturated counter still compares as "long enough"
    // instead of wrapping back to zero.
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    if (!ch_en_i) begin
      action = FILT_DISABLED;
    end else if (sync_bit == level_q) begin
      action = FILT_HOLD;
    end else if (cnt_inc >= {1'b0, len_eff}) begin
      action = FILT_UPDATE;
    end else begin
      action = FILT_COUNT;
    end
  end

  // Derive next counter, level and pulse values from the classification.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (action)
      FILT_COUNT: begin
        // Safe truncation: counting only happens while cnt_inc < len_eff.
        cnt_d = cnt_inc[CNT_W-1:0];
      end
      FILT_UPDATE: begin
        level_d = sync_bit;
        rise_d  = sync_bit;
        fall_d  = ~sync_bit;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d = (cnt_d != '0);
  end

  // Channel state registers; reset puts the synchroniser and output at the
  // initial level so nothing looks like an edge when reset is released.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: the reset branch loads constants only and the async reset sits in
    // the sensitivity list, so asserting rst_n aborts qualification at once
    // without waiting for a clock edge.
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{INIT_BIT}};
      cnt_q   <= '0;
      level_q <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the synchroniser chain into one stage.
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign filter_opt_o = level_q;
  assign opt_rise_o   = rise_q;
  assign opt_fall_o   = fall_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/cb_io_filter_mc.sv
// Multi-channel debounce filter for asynchronous IO / photoelectric inputs.
// Each channel is an independent cb_io_filter_cell sharing the runtime
// filter length.
module cb_io_filter_mc
  import cb_io_filter_pkg::*;
#(
  parameter int                CH_NUM      = CH_NUM_DEF,
  parameter int                CNT_W       = CNT_W_DEF,
  parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [CH_NUM-1:0] INIT_LEVEL  = '0
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] orign_opt_i,
  input  logic [CNT_W-1:0]  filt_len_i,
  input  logic [CH_NUM-1:0] ch_en_i,
  output logic [CH_NUM-1:0] filter_opt_o,
  output logic [CH_NUM-1:0] opt_rise_o,
  output logic [CH_NUM-1:0] opt_fall_o,
  output logic [CH_NUM-1:0] busy_o
);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    cb_io_filter_cell #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_BIT    (INIT_LEVEL[g])
    ) u_cell (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .orign_opt_i  (orign_opt_i[g]),
      .filt_len_i   (filt_len_i),
      .ch_en_i      (ch_en_i[g]),
      .filter_opt_o (filter_opt_o[g]),
      .opt_rise_o   (opt_rise_o[g]),
      .opt_fall_o   (opt_fall_o[g]),
      .busy_o       (busy_o[g])
    );
  end

endmodule

// File: tb/tb_cb_io_filter_mc.sv
// Bench for cb_io_filter_mc: two 4-channel instances (reset levels 0000 and
// 1010) share all inputs and are compared every cycle against a run-length
// reference model, plus directed timing checks for each scenario.
module tb_cb_io_filter_mc;

  localparam int             CH     = 4;
  localparam int             CW     = 8;
  localparam int             SS     = 2;
  localparam logic [CH-1:0]  INIT_A = 4'b0000;
  localparam logic [CH-1:0]  INIT_B = 4'b1010;

  logic          sys_clk  = 1'b0;
  logic          rst_n    = 1'b0;
  logic [CH-1:0] pins     = '0;
  logic [CW-1:0] filt_len = 8'd4;
  logic [CH-1:0] ch_en    = '1;

  logic [CH-1:0] d_filt [2];
  logic [CH-1:0] d_rise [2];
  logic [CH-1:0] d_fall [2];
  logic [CH-1:0] d_busy [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  cb_io_filter_mc #(
    .CH_NUM(CH), .CNT_W(CW), .SYNC_STAGES(SS), .INIT_LEVEL(INIT_A)
  ) u_dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .orign_opt_i(pins), .filt_len_i(filt_len),
    .ch_en_i(ch_en), .filter_opt_o(d_filt[0]), .opt_rise_o(d_rise[0]),
    .opt_fall_o(d_fall[0]), .busy_o(d_busy[0])
  );

  cb_io_filter_mc #(
    .CH_NUM(CH), .CNT_W(CW), .SYNC_STAGES(SS), .INIT_LEVEL(INIT_B)
  ) u_dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .orign_opt_i(pins), .filt_len_i(filt_len),
    .ch_en_i(ch_en), .filter_opt_o(d_filt[1]), .opt_rise_o(d_rise[1]),
    .opt_fall_o(d_fall[1]), .busy_o(d_busy[1])
  );

  // ---------------- reference model ----------------
  // The filtered level flips once the pin, as seen SS edges late, has
  // disagreed with it for max(len,1) consecutive enabled samples.
  logic [CH-1:0] pin_hist [SS];     // pin_hist[j]: pin taken j+1 edges ago
  int            m_age;             // edges since reset, capped at SS
  logic [CH-1:0] m_filt [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];
  logic [CH-1:0] m_busy [2];
  int            m_run  [2][CH];    // length of the current disagreeing run

  function automatic logic [CH-1:0] init_of(input int k);
    return (k == 0) ? INIT_A : INIT_B;
  endfunction

  task automatic model_reset();
    m_age = 0;
    for (int k = 0; k < 2; k++) begin
      m_filt[k] = init_of(k);
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_busy[k] = '0;
      for (int c = 0; c < CH; c++) m_run[k][c] = 0;
    end
  endtask

  task automatic model_step();
    int            len;
    logic [CH-1:0] seen;
    len = (filt_len == '0) ? 1 : int'(filt_len);
    for (int k = 0; k < 2; k++) begin
      seen      = (m_age >= SS) ? pin_hist[SS-1] : init_of(k);
      m_rise[k] = '0;
      m_fall[k] = '0;
      for (int c = 0; c < CH; c++) begin
        if (!ch_en[c] || seen[c] == m_filt[k][c]) begin
          m_run[k][c] = 0;
        end else if (m_run[k][c] + 1 >= len) begin
          m_filt[k][c] = seen[c];
          if (seen[c]) m_rise[k][c] = 1'b1;
          else         m_fall[k][c] = 1'b1;
          m_run[k][c] = 0;
        end else begin
          m_run[k][c] = m_run[k][c] + 1;
        end
        m_busy[k][c] = (m_run[k][c] != 0);
      end
    end
    for (int s = SS - 1; s > 0; s--) pin_hist[s] = pin_hist[s-1];
    pin_hist[0] = pins;
    if (m_age < SS) m_age = m_age + 1;
  endtask

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scenarios ----------------
  // Inputs change just after a falling edge; outputs are read on it.

  task automatic test_reset();
    rst_n = 1'b0; pins = '0; ch_en = '1; filt_len = 8'd4;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (d_filt[0] !== 4'b0000) begin
      n_bad++; $display("FAIL reset_level_a: got %b want 0000", d_filt[0]);
    end
    n_cmp++;
    if (d_filt[1] !== 4'b1010) begin
      n_bad++; $display("FAIL reset_level_b: got %b want 1010", d_filt[1]);
    end
    n_cmp++;
    if ({d_rise[0], d_fall[0], d_busy[0], d_rise[1], d_fall[1], d_busy[1]} !== '0) begin
      n_bad++;
      $display("FAIL reset_flags: got rise/fall/busy a=%b/%b/%b b=%b/%b/%b want all 0",
               d_rise[0], d_fall[0], d_busy[0], d_rise[1], d_fall[1], d_busy[1]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL reset_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
    end
  endtask

  // ch0 0->1 with len 4: output at E0+5, one rise pulse, others untouched.
  task automatic test_rise_latency();
    filt_len = 8'd4;
    pins[0]  = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (d_filt[0] !== ((n >= 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++; $display("FAIL rise_latency n=%0d: got filt=%b want %b", n, d_filt[0], (n >= 6) ? 4'b0001 : 4'b0000);
      end
      n_cmp++;
      if ({d_rise[0], d_fall[0]} !== {((n == 6) ? 4'b0001 : 4'b0000), 4'b0000}) begin
        n_bad++; $display("FAIL rise_pulse n=%0d: got rise=%b fall=%b", n, d_rise[0], d_fall[0]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL rise_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
    end
  endtask

  // ch1 high for only 3 samples with len 4: busy 3 cycles, no change.
  task automatic test_short_pulse();
    filt_len = 8'd4;
    pins[1]  = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (d_busy[0][1] !== ((n >= 3 && n <= 5) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL short_busy n=%0d: got %b", n, d_busy[0][1]);
      end
      n_cmp++;
      if ({d_filt[0], d_rise[0], d_fall[0]} !== {4'b0001, 4'b0000, 4'b0000}) begin
        n_bad++; $display("FAIL short_hold n=%0d: got filt=%b rise=%b fall=%b want 0001 0000 0000",
                          n, d_filt[0], d_rise[0], d_fall[0]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL short_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
      if (n == 3) pins[1] = 1'b0;
    end
  endtask

  // len 0 behaves as 1: output follows at E0+2; a 1-cycle glitch passes.
  task automatic test_min_len();
    filt_len = 8'd0;
    pins[2]  = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (d_filt[0][2] !== ((n >= 3) ? 1'b1 : 1'b0) || d_rise[0][2] !== ((n == 3) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL len0_follow n=%0d: got filt=%b rise=%b", n, d_filt[0][2], d_rise[0][2]);
      end
    end
    filt_len = 8'd1;
    pins[2]  = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({d_filt[0][2], d_fall[0][2], d_rise[0][2]} !==
          {((n == 3) ? 1'b0 : 1'b1), ((n == 3) ? 1'b1 : 1'b0), ((n == 4) ? 1'b1 : 1'b0)}) begin
        n_bad++; $display("FAIL len1_glitch n=%0d: got filt=%b fall=%b rise=%b",
                          n, d_filt[0][2], d_fall[0][2], d_rise[0][2]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL minlen_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
      if (n == 1) pins[2] = 1'b1;
    end
  endtask

  // len 200 cut to 5 while cnt is 10: next mismatching sample updates.
  task automatic test_len_reduce();
    filt_len = 8'd200;
    pins[0]  = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (d_filt[0][0] !== ((n >= 13) ? 1'b0 : 1'b1) || d_fall[0][0] !== ((n == 13) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL len_reduce n=%0d: got filt=%b fall=%b", n, d_filt[0][0], d_fall[0][0]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL reduce_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
      if (n == 12) begin
        n_cmp++;
        if (d_busy[0][0] !== 1'b1 || m_run[0][0] != 10) begin
          n_bad++; $display("FAIL len_reduce_busy: got busy=%b model run=%0d want 1 and 10", d_busy[0][0], m_run[0][0]);
        end
        filt_len = 8'd5;
      end
    end
  endtask

  // ch2 disabled while bouncing: held, silent; re-enable qualifies from 0.
  task automatic test_disable();
    filt_len = 8'd4;
    pins[2]  = 1'b0;
    repeat (8) @(negedge sys_clk);
    ch_en[2] = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({d_filt[0][2], d_rise[0][2], d_fall[0][2], d_busy[0][2]} !== 4'b0000) begin
        n_bad++; $display("FAIL disabled_hold n=%0d: got filt=%b rise=%b fall=%b busy=%b want 0 0 0 0",
                          n, d_filt[0][2], d_rise[0][2], d_fall[0][2], d_busy[0][2]);
      end
      pins[2] = (n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ch_en[2] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (d_filt[0][2] !== ((n >= 4) ? 1'b1 : 1'b0) || d_rise[0][2] !== ((n == 4) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL reenable n=%0d: got filt=%b rise=%b", n, d_filt[0][2], d_rise[0][2]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL enable_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
    end
  endtask

  // Reset during qualification on the 1010 instance: abort, no pulses.
  task automatic test_reset_mid();
    filt_len = 8'd1;
    pins     = INIT_B;
    repeat (6) @(negedge sys_clk);
    filt_len = 8'd8;
    pins     = ~INIT_B;
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if (d_busy[1] !== 4'b1111 || d_filt[1] !== INIT_B) begin
      n_bad++; $display("FAIL mid_qualify: got busy=%b filt=%b want 1111 1010", d_busy[1], d_filt[1]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_filt[1], d_rise[1], d_fall[1], d_busy[1]} !== {INIT_B, 12'h000}) begin
      n_bad++; $display("FAIL reset_abort: got filt=%b rise=%b fall=%b busy=%b want 1010 0000 0000 0000",
                        d_filt[1], d_rise[1], d_fall[1], d_busy[1]);
    end
    pins = INIT_B;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({d_filt[1], d_rise[1], d_fall[1]} !== {INIT_B, 8'h00}) begin
        n_bad++; $display("FAIL post_reset n=%0d: got filt=%b rise=%b fall=%b want 1010 0000 0000",
                          n, d_filt[1], d_rise[1], d_fall[1]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL rstmid_model dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
      end
    end
  endtask

  // Random bouncing pins, lengths and enables against the model.
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_filt[k], d_rise[k], d_fall[k], d_busy[k]} !== {m_filt[k], m_rise[k], m_fall[k], m_busy[k]}) begin
          n_bad++;
          $display("FAIL random_model n=%0d dut%0d: got filt=%b rise=%b fall=%b busy=%b want %b %b %b %b",
                   n, k, d_filt[k], d_rise[k], d_fall[k], d_busy[k], m_filt[k], m_rise[k], m_fall[k], m_busy[k]);
        end
        n_cmp++;
        if ((d_rise[k] & d_fall[k]) !== 4'b0000) begin
          n_bad++; $display("FAIL random_exclusive n=%0d dut%0d: rise=%b fall=%b overlap", n, k, d_rise[k], d_fall[k]);
        end
      end
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) pins[c] = ~pins[c];
      end
      if (n % 16 == 0) begin
        filt_len = 8'($urandom_range(0, 6));
        for (int c = 0; c < CH; c++) ch_en[c] = ($urandom_range(0, 7) != 0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise_latency();
    test_short_pulse();
    test_min_len();
    test_len_reduce();
    test_disable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cb_io_filter_mc.md
CB_IO_FILTER_MC -- requirements
Module: cb_io_filter_mc

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 8: number of independent input channels, range 1..32.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the runtime filter-length input and of each per-channel counter.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, range 2..4.
REQ-004 The block SHALL have parameter INIT_LEVEL, default all zeros: CH_NUM-bit reset level, one bit per channel.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock; every flop SHALL be clocked by it.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port orign_opt_i, input, CH_NUM bits: raw asynchronous IO/photoelectric inputs.
REQ-008 The block SHALL have port filt_len_i, input, CNT_W bits: required consecutive mismatching samples; the value 0 SHALL be treated as 1.
REQ-009 The block SHALL have port ch_en_i, input, CH_NUM bits: per-channel filter enable.
REQ-010 The block SHALL have port filter_opt_o, output, CH_NUM bits: filtered level.
REQ-011 The block SHALL have port opt_rise_o, output, CH_NUM bits: one-cycle pulse when filter_opt_o[i] goes 0->1.
REQ-012 The block SHALL have port opt_fall_o, output, CH_NUM bits: one-cycle pulse when filter_opt_o[i] goes 1->0.
REQ-013 The block SHALL have port busy_o, output, CH_NUM bits: channel i counter is non-zero (qualification in progress).

Function
REQ-014 Each channel SHALL pass orign_opt_i[i] through a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
REQ-015 Each channel SHALL have one sample per sys_clk edge; a sample is a mismatch when sync[i] != filter_opt_o[i].
REQ-016 Matching sample: cnt[i] SHALL be set to 0 and the output held; any bounce therefore restarts qualification.
REQ-017 Mismatching sample with cnt[i]+1 >= max(filt_len_i,1): filter_opt_o[i] SHALL be set to sync[i], cnt[i] set to 0, and the matching rise/fall pulse asserted for exactly that one following cycle.
REQ-018 Mismatching sample otherwise: cnt[i] SHALL be set to cnt[i]+1; the compare SHALL use a CNT_W+1-bit sum and the counter SHALL never wrap.
REQ-019 Latency: with the pin stable from edge E0, the first edge that samples the new pin value, filter_opt_o SHALL change at edge E0+SYNC_STAGES+max(filt_len_i,1)-1.
REQ-020 The filt_len_i value SHALL be read every edge; if it is reduced mid-qualification to a value <= cnt[i]+1, the next mismatching sample SHALL update the output.
REQ-021 When ch_en_i[i]=0, cnt[i] SHALL be forced to 0, filter_opt_o[i] held, and no pulses generated, while the synchroniser keeps running; after re-enable, qualification SHALL start from cnt=0.
REQ-022 opt_rise_o[i] and opt_fall_o[i] SHALL never be high in the same cycle; back-to-back output changes SHALL be at least max(filt_len_i,1) cycles apart.
REQ-023 busy_o[i] SHALL equal (cnt[i] != 0), registered with no extra latency.
REQ-024 Channels SHALL be fully independent; simultaneous events on all channels SHALL be handled in the same cycle.

Reset
REQ-025 While rst_n=0, all synchroniser stages and filter_opt_o SHALL equal INIT_LEVEL, so no spurious edge occurs after release.
REQ-026 While rst_n=0, cnt, opt_rise_o, opt_fall_o and busy_o SHALL be 0.
REQ-027 Reset asserted mid-qualification SHALL abort it immediately with no pulse generated.

Structure
REQ-028 A shared package/header cb_io_filter_pkg SHALL hold the default CH_NUM, CNT_W and SYNC_STAGES and the clog2 helper function.
REQ-029 The per-channel logic (synchroniser, counter, output and pulse flops) SHALL be the sub-module cb_io_filter_cell, instantiated CH_NUM times by a generate loop.

Verification
REQ-030 The bench SHALL cover: CH_NUM=4, SYNC=2, filt_len=4, ch0 0->1 at E0 -> filter_opt_o[0]=1 at E0+5, opt_rise_o[0] high one cycle, other channels unchanged.
REQ-031 The bench SHALL cover: filt_len=4, ch1 high for 3 cycles then low -> no output change, no pulse, busy_o[1] high 3 cycles then 0.
REQ-032 The bench SHALL cover: filt_len=0 and then 1 -> output follows the pin at E0+2, and a 1-cycle glitch passes.
REQ-033 The bench SHALL cover: filt_len=200 reduced to 5 when cnt=10 -> output updates on the next mismatching sample.
REQ-034 The bench SHALL cover: ch_en_i[2]=0 while ch2 toggles -> output held, no pulses; re-enable with the pin stable for 4 samples -> update.
REQ-035 The bench SHALL cover: INIT_LEVEL=4'b1010, rst_n pulsed low during qualification -> outputs 1010, no pulses, cnt 0.
